// File: rtl/t_flip_flop_pkg.sv
// t_flip_flop_pkg: shared definitions for the T flip-flop bank.
//   TFF_RESET_Q   default reset value of a single cell
//   tff_state_t   per-cell stored state
//   TFF_MSG_*     assertion messages, used when T_FLIP_FLOP_ASSERT_EN is defined
package t_flip_flop_pkg;

  typedef logic tff_state_t;

  localparam tff_state_t TFF_RESET_Q = 1'b0;

  localparam string TFF_MSG_QB    = "t_flip_flop: Qb_Out is not the complement of Q_Out";
  localparam string TFF_MSG_RST   = "t_flip_flop: Q_Out did not load RESET_Q after reset";
  localparam string TFF_MSG_TOG   = "t_flip_flop: Q_Out is not past Q_Out xor past T_In";
  localparam string TFF_MSG_T_UNK = "t_flip_flop: T_In is X/Z at an edge outside reset";

endpackage

// File: rtl/tff_cell.sv
// tff_cell: single-bit toggle register with synchronous active-high reset.
//   clk_i  rising-edge clock
//   rst_i  synchronous reset; loads RST_VAL, overrides t_i
//   t_i    1 = invert on next edge, 0 = hold
//   q_o    registered state
//   qb_o   complement of q_o, derived from the same flop
module tff_cell
  import t_flip_flop_pkg::*;
#(
  parameter tff_state_t RST_VAL = TFF_RESET_Q
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic t_i,
  output logic q_o,
  output logic qb_o
);

  tff_state_t q_q, q_d;

  // Reset is selected first so an unknown t_i during reset never reaches q_q.
  always_comb begin
    q_d = q_q;
    if (rst_i) q_d = RST_VAL;
    else       q_d = q_q ^ t_i;
  end

  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o  = q_q;
  assign qb_o = ~q_q;

endmodule

// File: rtl/t_flip_flop.sv
// t_flip_flop: bank of WIDTH independent toggle flip-flops with complementary
// outputs and synchronous active-high reset.
//   Clk_In    rising-edge clock
//   Reset_In  synchronous reset; Q_Out <= RESET_Q
//   T_In      per-bit toggle request
//   Q_Out     registered state
//   Qb_Out    ~Q_Out
// Optional: define T_FLIP_FLOP_ASSERT_EN to compile in concurrent assertions.
module t_flip_flop
  import t_flip_flop_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RESET_Q = {WIDTH{TFF_RESET_Q}}
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic [WIDTH-1:0] T_In,
  output logic [WIDTH-1:0] Q_Out,
  output logic [WIDTH-1:0] Qb_Out
);

  // Cells share only clock and reset; no carry between bits.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell #(
      .RST_VAL (RESET_Q[i])
    ) u_cell (
      .clk_i (Clk_In),
      .rst_i (Reset_In),
      .t_i   (T_In[i]),
      .q_o   (Q_Out[i]),
      .qb_o  (Qb_Out[i])
    );
  end

`ifdef T_FLIP_FLOP_ASSERT_EN
  // Outputs are undefined until the first reset edge, so checks are gated.
  logic seen_rst_q;
  always_ff @(posedge Clk_In) begin
    if (Reset_In) seen_rst_q <= 1'b1;
  end

  a_qb_comp: assert property (@(posedge Clk_In)
    seen_rst_q |-> (Qb_Out == ~Q_Out))
    else $error("%s", TFF_MSG_QB);

  a_rst_load: assert property (@(posedge Clk_In)
    Reset_In |=> (Q_Out == RESET_Q))
    else $error("%s", TFF_MSG_RST);

  a_toggle: assert property (@(posedge Clk_In)
    (seen_rst_q && !Reset_In) |=> (Q_Out == ($past(Q_Out) ^ $past(T_In))))
    else $error("%s", TFF_MSG_TOG);

  a_t_known: assert property (@(posedge Clk_In)
    (seen_rst_q && !Reset_In) |-> !$isunknown(T_In))
    else $error("%s", TFF_MSG_T_UNK);
`else
`endif

endmodule

// File: tb/tb_t_flip_flop.sv
module tb_t_flip_flop;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // single-bit instance, RESET_Q = 0
  logic rst1, t1, q1, qb1;
  // four-bit instance, RESET_Q = 4'b1010
  logic       rst4;
  logic [3:0] t4, q4, qb4;

  t_flip_flop #(.WIDTH(1), .RESET_Q(1'b0)) dut1 (
    .Clk_In(clk), .Reset_In(rst1), .T_In(t1), .Q_Out(q1), .Qb_Out(qb1)
  );

  t_flip_flop #(.WIDTH(4), .RESET_Q(4'b1010)) dut4 (
    .Clk_In(clk), .Reset_In(rst4), .T_In(t4), .Q_Out(q4), .Qb_Out(qb4)
  );

  int checks = 0;
  int errors = 0;

  logic       exp1_q[$];
  logic [3:0] exp4_q[$];

  // Drive mid-cycle, record the expected result, then move just past the edge.
  task automatic drive1(input logic rst, input logic t, input logic exp);
    @(negedge clk);
    rst1 = rst;
    t1   = t;
    exp1_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic rst, input logic [3:0] t, input logic [3:0] exp);
    @(negedge clk);
    rst4 = rst;
    t4   = t;
    exp4_q.push_back(exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic e;
    drive1(1'b1, 1'bx, 1'b0);
    e = (exp1_q.size() != 0) ? exp1_q.pop_front() : 1'bx;
    checks++;
    if (q1 !== e) begin errors++; $display("FAIL reset_q: got %b expected %b", q1, e); end
    checks++;
    if (qb1 !== ~e) begin errors++; $display("FAIL reset_qb: got %b expected %b", qb1, ~e); end
  endtask

  task automatic test_hold;
    logic e;
    drive1(1'b1, 1'b0, 1'b0);
    void'(exp1_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive1(1'b0, 1'b0, 1'b0);
      e = exp1_q.pop_front();
      checks++;
      if (q1 !== e || qb1 !== ~e) begin
        errors++;
        $display("FAIL hold[%0d]: got q=%b qb=%b expected q=%b qb=%b", i, q1, qb1, e, ~e);
      end
    end
    // Reset pulse and T pulse between edges must not reach the outputs.
    @(negedge clk);
    rst1 = 1'b1; t1 = 1'b1;
    #2;
    rst1 = 1'b0; t1 = 1'b0;
    #1;
    checks++;
    if (q1 !== 1'b0 || qb1 !== 1'b1) begin
      errors++;
      $display("FAIL no_async: got q=%b qb=%b expected q=0 qb=1", q1, qb1);
    end
  endtask

  task automatic test_toggle;
    logic ev[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic e;
    drive1(1'b1, 1'b0, 1'b0);
    void'(exp1_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive1(1'b0, 1'b1, ev[i]);
      e = exp1_q.pop_front();
      checks++;
      if (q1 !== e || qb1 !== ~e) begin
        errors++;
        $display("FAIL toggle[%0d]: got q=%b qb=%b expected q=%b qb=%b", i, q1, qb1, e, ~e);
      end
    end
  endtask

  task automatic test_mixed;
    logic tv[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic ev[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic e;
    drive1(1'b1, 1'b0, 1'b0);
    void'(exp1_q.pop_front());
    for (int i = 0; i < 7; i++) begin
      drive1(1'b0, tv[i], ev[i]);
      e = exp1_q.pop_front();
      checks++;
      if (q1 !== e || qb1 !== ~e) begin
        errors++;
        $display("FAIL mixed[%0d]: got q=%b qb=%b expected q=%b qb=%b", i, q1, qb1, e, ~e);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic tv[3] = '{1'b0, 1'b1, 1'b1};
    logic rv[3] = '{1'b0, 1'b1, 1'b0};
    logic ev[3] = '{1'b1, 1'b0, 1'b1};
    logic e;
    // Previous test leaves Q=0; first step toggles to 1 with T=1.
    for (int i = 0; i < 3; i++) begin
      drive1(rv[i], (i == 0) ? 1'b1 : tv[i], ev[i]);
      e = exp1_q.pop_front();
      checks++;
      if (q1 !== e || qb1 !== ~e) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got q=%b qb=%b expected q=%b qb=%b", i, q1, qb1, e, ~e);
      end
    end
  endtask

  task automatic test_wide;
    logic [3:0] tv[3] = '{4'bxxxx, 4'b0110, 4'b1111};
    logic       rv[3] = '{1'b1,    1'b0,    1'b0};
    logic [3:0] ev[3] = '{4'b1010, 4'b1100, 4'b0011};
    logic [3:0] e;
    for (int i = 0; i < 3; i++) begin
      drive4(rv[i], tv[i], ev[i]);
      e = exp4_q.pop_front();
      checks++;
      if (q4 !== e) begin
        errors++;
        $display("FAIL wide_q[%0d]: got %b expected %b", i, q4, e);
      end
      checks++;
      if (qb4 !== ~e) begin
        errors++;
        $display("FAIL wide_qb[%0d]: got %b expected %b", i, qb4, ~e);
      end
    end
  endtask

  initial begin
    rst1 = 1'b1; t1 = 1'bx;
    rst4 = 1'b1; t4 = 4'bxxxx;
    test_reset();
    test_hold();
    test_toggle();
    test_mixed();
    test_reset_mid();
    test_wide();
    checks++;
    if (exp1_q.size() != 0 || exp4_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d left expected 0/0",
               exp1_q.size(), exp4_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
